procyon_wb_sram: RTL and testbench

//   Wishbone B4 classic/registered-feedback slave memory: the responder end of the wishbone master bus interface.

---
 rtl/procyon_wb_sram.sv | 145 ++++++++++++++
 tb/tb_procyon_wb_sram.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/procyon_wb_sram.sv
// Wishbone B4 slave memory with classic and CTI/BTE burst support.
// Serves cache line fills and writebacks from an internal word array.
module procyon_wb_sram #(
    parameter int OPTN_WB_DATA_WIDTH = 16,
    parameter int OPTN_WB_ADDR_WIDTH = 32,
    parameter int OPTN_MEM_SIZE      = 1024,
    parameter int OPTN_WAIT_STATES   = 0
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            i_wb_cyc,
    input  logic                            i_wb_stb,
    input  logic                            i_wb_we,
    input  logic [2:0]                      i_wb_cti,
    input  logic [1:0]                      i_wb_bte,
    input  logic [OPTN_WB_DATA_WIDTH/8-1:0] i_wb_sel,
    input  logic [OPTN_WB_ADDR_WIDTH-1:0]   i_wb_addr,
    input  logic [OPTN_WB_DATA_WIDTH-1:0]   i_wb_data,
    output logic                            o_wb_ack,
    output logic [OPTN_WB_DATA_WIDTH-1:0]   o_wb_data
);

    localparam int WB_DATA_SIZE = OPTN_WB_DATA_WIDTH / 8;
    localparam int MEM_DEPTH    = OPTN_MEM_SIZE / WB_DATA_SIZE;
    localparam int IDX_W        = $clog2(MEM_DEPTH);
    localparam int LSB_W        = $clog2(WB_DATA_SIZE);
    localparam logic [2:0] CTI_INCR  = 3'b010;
    localparam logic [3:0] WAIT_INIT = 4'(OPTN_WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, CLASSIC, BURST} state_t;

    state_t                          state_q, state_d;
    logic                            ack_q, ack_d;
    logic [3:0]                      wait_q, wait_d;
    logic [2:0]                      cti_q, cti_d;
    logic [IDX_W-1:0]                idx_q, idx_d, idx_adv, wrap_mask, addr_idx;
    logic [OPTN_WB_DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic [OPTN_WB_DATA_WIDTH-1:0]   wr_word, rd_word, data_q;
    logic                            beat, wr_en;
    logic                            unused_addr;

    assign addr_idx    = i_wb_addr[LSB_W +: IDX_W];
    assign unused_addr = ^i_wb_addr;
    assign beat        = ack_q & i_wb_cyc & i_wb_stb;
    assign wr_en       = beat & i_wb_we;
    assign o_wb_ack    = beat;
    assign o_wb_data   = data_q;

    // Wrapping bursts only advance the low log2(N) index bits
    always_comb begin
        case (i_wb_bte)
            2'b01:   wrap_mask = IDX_W'(3);
            2'b10:   wrap_mask = IDX_W'(7);
            2'b11:   wrap_mask = IDX_W'(15);
            default: wrap_mask = '1;
        endcase
        idx_adv = (idx_q & ~wrap_mask) | ((idx_q + IDX_W'(1)) & wrap_mask);
    end

    always_comb begin
        wr_word = mem[idx_q];
        for (int unsigned b = 0; b < WB_DATA_SIZE; b++) begin
            if (i_wb_sel[b]) wr_word[b*8 +: 8] = i_wb_data[b*8 +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        wait_d  = wait_q;
        cti_d   = cti_q;
        idx_d   = idx_q;
        if (!i_wb_cyc) begin
            state_d = IDLE;
            ack_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_wb_stb) begin
                        idx_d = addr_idx;
                        cti_d = i_wb_cti;
                        if (OPTN_WAIT_STATES == 0) begin
                            ack_d   = 1'b1;
                            state_d = (i_wb_cti == CTI_INCR) ? BURST : CLASSIC;
                        end else begin
                            state_d = WAIT;
                            wait_d  = WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    wait_d = wait_q - 4'd1;
                    if (wait_q == 4'd1) begin
                        ack_d   = 1'b1;
                        state_d = (cti_q == CTI_INCR) ? BURST : CLASSIC;
                    end
                end
                CLASSIC: begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
                BURST: begin
                    if (i_wb_stb) begin
                        if (i_wb_cti == CTI_INCR) begin
                            idx_d = idx_adv;
                        end else begin
                            ack_d   = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Read data is fetched for the upcoming ack cycle; forward a same-word write
    assign rd_word = (wr_en && (idx_d == idx_q)) ? wr_word : mem[idx_d];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            wait_q  <= '0;
            cti_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            wait_q  <= wait_d;
            cti_q   <= cti_d;
            idx_q   <= idx_d;
            if (ack_d) data_q <= rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[idx_q] <= wr_word;
    end

endmodule

// File: tb/tb_procyon_wb_sram.sv
// Directed bench for procyon_wb_sram: classic, incr/wrap bursts, byte
// enables, stalls, wait states, dropped cycles and mid-burst reset.
module tb_procyon_wb_sram;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        cyc, stb, we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [1:0]  sel;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic        ack, ack2;
    logic [15:0] rdata, rdata2;

    int checks = 0;
    int errors = 0;

    logic [15:0] t3_exp [5] = '{16'h0303, 16'h0000, 16'h0101, 16'h0202, 16'h0303};

    always #5 clk = ~clk;

    procyon_wb_sram #(
        .OPTN_WB_DATA_WIDTH(16),
        .OPTN_WB_ADDR_WIDTH(32),
        .OPTN_MEM_SIZE(1024),
        .OPTN_WAIT_STATES(0)
    ) dut (
        .clk(clk), .n_rst(n_rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_cti(cti), .i_wb_bte(bte), .i_wb_sel(sel), .i_wb_addr(addr),
        .i_wb_data(wdata), .o_wb_ack(ack), .o_wb_data(rdata)
    );

    procyon_wb_sram #(
        .OPTN_WB_DATA_WIDTH(16),
        .OPTN_WB_ADDR_WIDTH(32),
        .OPTN_MEM_SIZE(1024),
        .OPTN_WAIT_STATES(2)
    ) dut2 (
        .clk(clk), .n_rst(n_rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_cti(cti), .i_wb_bte(bte), .i_wb_sel(sel), .i_wb_addr(addr),
        .i_wb_data(wdata), .o_wb_ack(ack2), .o_wb_data(rdata2)
    );

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_bus();
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        cti = 3'b000;
        bte = 2'b00;
    endtask

    // One classic cycle on the zero-wait slave: no ack, ack, then no ack
    task automatic classic(input logic w, input logic [31:0] a, input logic [15:0] d,
                           input logic [1:0] s, input logic [15:0] exp, input string tag);
        cyc = 1'b1; stb = 1'b1; we = w; cti = 3'b000; bte = 2'b00;
        addr = a; wdata = d; sel = s;
        smp();
        chk_bit({tag, "_ack_pre"}, ack, 1'b0);
        nxt();
        smp();
        chk_bit({tag, "_ack"}, ack, 1'b1);
        if (!w) chk_word({tag, "_data"}, rdata, exp);
        nxt();
        idle_bus();
        sel = 2'b11;
        smp();
        chk_bit({tag, "_ack_post"}, ack, 1'b0);
        nxt();
    endtask

    initial begin
        n_rst = 1'b0;
        idle_bus();
        sel = 2'b11; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        smp();
        chk_bit("reset_ack", ack, 1'b0);
        chk_word("reset_data", rdata, 16'h0000);
        chk_bit("reset_ack_w2", ack2, 1'b0);
        chk_word("reset_data_w2", rdata2, 16'h0000);
        nxt();
        n_rst = 1'b1;
        nxt();

        // 1: classic write then read
        classic(1'b1, 32'h10, 16'hBEEF, 2'b11, 16'h0000, "t1_wr");
        classic(1'b0, 32'h10, 16'h0000, 2'b11, 16'hBEEF, "t1_rd");

        // 2: preload then 16-beat incrementing read
        for (int k = 0; k < 16; k++) classic(1'b1, 32'(k * 2), 16'(k * 257), 2'b11, 16'h0, "t2_pre");
        cyc = 1'b1; stb = 1'b1; we = 1'b0; cti = 3'b010; bte = 2'b00; addr = '0;
        smp();
        chk_bit("t2_ack_pre", ack, 1'b0);
        for (int k = 0; k < 16; k++) begin
            nxt();
            cti  = (k == 15) ? 3'b111 : 3'b010;
            addr = 32'(k * 2);
            smp();
            chk_bit("t2_ack", ack, 1'b1);
            chk_word("t2_data", rdata, 16'(k * 257));
        end
        nxt();
        cti = 3'b000;
        smp();
        chk_bit("t2_ack_end", ack, 1'b0);
        nxt();
        idle_bus();
        smp();
        chk_bit("t2_ack_drop", ack, 1'b0);
        nxt();

        // 3: wrap4 read from 0x6
        cyc = 1'b1; stb = 1'b1; we = 1'b0; cti = 3'b010; bte = 2'b01; addr = 32'h6;
        smp();
        chk_bit("t3_ack_pre", ack, 1'b0);
        for (int k = 0; k < 5; k++) begin
            nxt();
            cti = (k == 4) ? 3'b111 : 3'b010;
            smp();
            chk_bit("t3_ack", ack, 1'b1);
            chk_word("t3_data", rdata, t3_exp[k]);
        end
        nxt();
        idle_bus();
        smp();
        chk_bit("t3_ack_post", ack, 1'b0);
        nxt();

        // 4: byte-enable partial write
        classic(1'b1, 32'h20, 16'hBEEF, 2'b11, 16'h0000, "t4_wr_full");
        classic(1'b1, 32'h20, 16'h1234, 2'b01, 16'h0000, "t4_wr_lo");
        classic(1'b0, 32'h20, 16'h0000, 2'b11, 16'hBE34, "t4_rd");

        // 5: 16-beat write burst with a 2-cycle strobe gap before beat 6
        cyc = 1'b1; stb = 1'b1; we = 1'b1; cti = 3'b010; bte = 2'b00; addr = '0;
        wdata = 16'hA000; sel = 2'b11;
        smp();
        chk_bit("t5_ack_pre", ack, 1'b0);
        for (int k = 0; k < 16; k++) begin
            nxt();
            if (k == 6) begin
                stb = 1'b0;
                smp();
                chk_bit("t5_stall1", ack, 1'b0);
                nxt();
                smp();
                chk_bit("t5_stall2", ack, 1'b0);
                nxt();
                stb = 1'b1;
            end
            cti   = (k == 15) ? 3'b111 : 3'b010;
            wdata = 16'hA000 + 16'(k);
            addr  = 32'(k * 2);
            smp();
            chk_bit("t5_ack", ack, 1'b1);
        end
        nxt();
        idle_bus();
        smp();
        chk_bit("t5_ack_post", ack, 1'b0);
        nxt();
        for (int k = 0; k < 16; k++) classic(1'b0, 32'(k * 2), 16'h0, 2'b11, 16'hA000 + 16'(k), "t5_rd");

        // 6a: two wait states, first ack on the fourth cycle
        cyc = 1'b1; stb = 1'b1; we = 1'b1; cti = 3'b000; bte = 2'b00;
        addr = 32'h40; wdata = 16'h5A5A; sel = 2'b11;
        for (int c = 0; c < 4; c++) begin
            smp();
            chk_bit("t6_w2_wr_ack", ack2, c == 3);
            if (c < 3) nxt();
        end
        nxt();
        idle_bus();
        smp();
        chk_bit("t6_w2_wr_post", ack2, 1'b0);
        nxt();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; cti = 3'b000; addr = 32'h40;
        for (int c = 0; c < 4; c++) begin
            smp();
            chk_bit("t6_w2_rd_ack", ack2, c == 3);
            if (c == 3) chk_word("t6_w2_rd_data", rdata2, 16'h5A5A);
            if (c < 3) nxt();
        end
        nxt();
        idle_bus();
        smp();
        chk_bit("t6_w2_rd_post", ack2, 1'b0);
        nxt();

        // 6b: cyc dropped where beat 3 of a write burst would be
        for (int k = 0; k < 4; k++) classic(1'b1, 32'h100 + 32'(k * 2), 16'h0000, 2'b11, 16'h0, "t6_pre");
        cyc = 1'b1; stb = 1'b1; we = 1'b1; cti = 3'b010; bte = 2'b00;
        addr = 32'h100; wdata = 16'hC000;
        smp();
        chk_bit("t6_drop_ack_pre", ack, 1'b0);
        for (int k = 0; k < 3; k++) begin
            nxt();
            wdata = 16'hC000 + 16'(k);
            smp();
            chk_bit("t6_drop_beat_ack", ack, 1'b1);
        end
        nxt();
        cyc = 1'b0; stb = 1'b0; wdata = 16'hC003;
        smp();
        chk_bit("t6_drop_ack", ack, 1'b0);
        nxt();
        idle_bus();
        for (int k = 0; k < 4; k++)
            classic(1'b0, 32'h100 + 32'(k * 2), 16'h0, 2'b11, (k < 3) ? 16'hC000 + 16'(k) : 16'h0000, "t6_drop_rd");

        // 6c: reset pulse mid read burst
        cyc = 1'b1; stb = 1'b1; we = 1'b0; cti = 3'b010; bte = 2'b00; addr = '0;
        smp();
        chk_bit("t6_rst_ack_pre", ack, 1'b0);
        for (int k = 0; k < 2; k++) begin
            nxt();
            smp();
            chk_bit("t6_rst_beat_ack", ack, 1'b1);
            chk_word("t6_rst_beat_data", rdata, 16'hA000 + 16'(k));
        end
        nxt();
        #1 n_rst = 1'b0;
        #1;
        chk_bit("t6_rst_ack", ack, 1'b0);
        chk_word("t6_rst_data", rdata, 16'h0000);
        #1 n_rst = 1'b1;
        addr = 32'h4;
        smp();
        chk_bit("t6_rst_idle_ack", ack, 1'b0);
        nxt();
        cti = 3'b111;
        smp();
        chk_bit("t6_rst_restart_ack", ack, 1'b1);
        chk_word("t6_rst_restart_data", rdata, 16'hA002);
        nxt();
        idle_bus();
        smp();
        chk_bit("t6_rst_post", ack, 1'b0);
        nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
